mem_io_responder: RTL
=====================

# mem_io_responder

Memory/I/O responder for the RISCV32I core's byte-wide RAM bus. It answers the core's memory controller on the single-byte address/data interface. It provides 128 KB of RAM, a UART transmit path with the `io_buffer_full` back-pressure flag, a UART receive read port, a free-running cycle counter, and the program-stop register. It is the device side of the bus and replaces the board's RAM+HCI in simulation, so the core is tested against a cycle-exact model of the documented protocol.

## Interface
- `RAM_ADDR_W`, 17: RAM byte-address width (128 KB).
- `TX_DEPTH`, 16: UART TX FIFO depth; must be a power of 2 and ≥ 4.
- `FULL_MARGIN`, 2: free slots left when `io_buffer_full` asserts, covering the core's reaction latency.
- `INIT_FILE`, "": hex image loaded into RAM at time 0 (simulation only). An empty string means no load.

Ports. Reset is asynchronous and active-high.
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  asynchronous, active-high reset.
- `cpu_addr`  in  32  byte address; only bits [17:0] are decoded.
- `cpu_wr`  in  1  1 = write, 0 = read.
- `cpu_wdata`  in  8  write byte.
- `cpu_rdata`  out  8  read byte, registered.
- `io_buffer_full`  out  1  TX FIFO is at or above its high-water mark.
- `tx_valid`  out  1  TX FIFO is non-empty.
- `tx_byte`  out  8  TX FIFO head byte.
- `tx_ready`  in  1  consumer accepts `tx_byte` this cycle.
- `rx_valid`  in  1  an input byte is available.
- `rx_byte`  in  8  input byte.
- `rx_pop`  out  1  one-cycle pulse that consumes `rx_byte`.
- `prog_stop`  out  1  sticky; set by a write to 0x30004.
- `tx_overflow`  out  1  sticky; a TX push was dropped because the FIFO was full.

## Operation
- Address decode:
  - `cpu_addr[17:16]` = 2'b11: I/O space.
  - `cpu_addr[17:16]` = 2'b10: unmapped. Reads return 0x00; writes are ignored.
  - Otherwise: RAM at `cpu_addr[16:0]`.
- A transaction is issued every cycle; there is no idle signal. A read with no side effect is harmless.
- RAM write: the byte is stored at the clock edge.
- RAM read: the byte appears on `cpu_rdata` the next cycle.
- Read of 0x30000:
  - If `rx_valid`: return `rx_byte` and pulse `rx_pop` in the same cycle.
  - Otherwise: return 0x00 with no pop.
- Write of 0x30000:
  - Non-zero byte: push into the TX FIFO.
  - 0x00: ignored.
- Reads of 0x30004..0x30007:
  - A read of 0x30004 returns byte 0 of the 32-bit cycle counter and latches the whole counter into a snapshot register.
  - Reads of 0x30005–7 return snapshot bytes 1–3, so a 4-byte load is coherent.
- Write of 0x30004:
  - Set `prog_stop`.
  - Push 0x00 into the TX FIFO (bypasses the zero-ignore rule).
- Other I/O addresses: reads return 0x00; writes are ignored.
- Cycle counter: 32 bits, increments every cycle from 0 after reset, wraps from 0xFFFF_FFFF to 0.
- TX FIFO:
  - Pop happens when `tx_valid && tx_ready`.
  - A push and a pop in the same cycle are both performed; when full, a simultaneous pop frees the slot and the push succeeds.
  - A push into a full FIFO without a pop is dropped and sets `tx_overflow`.
  - `io_buffer_full` = (count ≥ `TX_DEPTH` − `FULL_MARGIN`), registered from the post-update count.
- Reset:
  - Clears the FIFO pointers and count, the counter, the snapshot, `prog_stop`, `tx_overflow`, and `cpu_rdata`.
  - RAM contents are not cleared.
  - Reset mid-transaction discards any pending read data.

## Timing
- Reset values: `cpu_rdata`=0, `io_buffer_full`=0, `tx_valid`=0, `tx_byte`=0, `rx_pop`=0, `prog_stop`=0, `tx_overflow`=0.
- Read latency is 1 cycle: the address at edge N gives data on `cpu_rdata` after edge N+1.
- Read-after-write to the same RAM byte in consecutive cycles returns the new value. Write at cycle N, read at N+1, data at N+2.
- `rx_pop` is combinational from the current address/`cpu_wr`/`rx_valid`. It is high only in the cycle the read is presented.
- A TX push at edge N gives `tx_valid` from N+1. `io_buffer_full` updates at the same edge as the count.
- `prog_stop` is high from the edge that accepts the 0x30004 write.

## Structure
- Shared constants go in `utils.v`:
  - `IO_BASE` 0x30000, `IO_CLK` 0x30004.
  - `RAM_SIZE`.
  - the I/O decode field [17:16].
- Sub-module `byte_fifo` (parameters `DEPTH`, `FULL_MARGIN`): push/pop/full/almost-full. It is reused by any future RX buffering.
- The RAM is an inferred `reg [7:0]` array with registered read. Decode, counter and snapshot live in the top module.

## Test plan
- Write 0xA5 to 0x00123, then read 0x00123 the next cycle → `cpu_rdata`=0xA5 two cycles after the write; reading 0x20010 → 0x00.
- Counter wraps: force it to 0xFFFF_FFFE, read 0x30004..7 over 4 cycles → bytes of 0xFFFF_FFFE (the snapshot), not the live value.
- `tx_ready`=0, write 14 non-zero bytes to 0x30000 → `io_buffer_full`=1 after the 14th push. Two more pushes fill the FIFO. The 17th push is dropped and sets `tx_overflow`. A 17th push with a simultaneous pop is accepted.
- Write 0x00 to 0x30000 → no push; write 0x00 to 0x30004 → push 0x00, `prog_stop`=1 the next cycle.
- `rx_valid`=1, `rx_byte`=0x41, read 0x30000 → `rx_pop` pulses 1 cycle, `cpu_rdata`=0x41; with `rx_valid`=0 → 0x00, no pop.
- Assert `rst_in` mid-burst with a non-empty FIFO → all outputs return to reset values asynchronously; previously written RAM bytes are still readable.

Source files
------------

// File: rtl/mem_io_responder_pkg.sv
// Shared bus constants and decode helpers for the byte-wide memory/I/O responder.
package mem_io_responder_pkg;

  localparam logic [17:0] IO_BASE = 18'h30000;
  localparam logic [17:0] IO_CLK  = 18'h30004;

  localparam int RAM_ADDR_W_DEF = 17;
  localparam int RAM_SIZE       = 1 << RAM_ADDR_W_DEF;

  localparam int         DEC_HI       = 17;
  localparam int         DEC_LO       = 16;
  localparam logic [1:0] DEC_IO       = 2'b11;
  localparam logic [1:0] DEC_UNMAPPED = 2'b10;

  typedef enum logic [1:0] {
    REGION_RAM      = 2'd0,
    REGION_UNMAPPED = 2'd1,
    REGION_IO       = 2'd2
  } region_e;

  // Which source drives cpu_rdata in the cycle after a read was presented.
  typedef enum logic {
    RSEL_IO  = 1'b0,
    RSEL_RAM = 1'b1
  } rsel_e;

  function automatic region_e decode_region(input logic [17:0] addr);
    if (addr[DEC_HI:DEC_LO] == DEC_IO) begin
      decode_region = REGION_IO;
    end else if (addr[DEC_HI:DEC_LO] == DEC_UNMAPPED) begin
      decode_region = REGION_UNMAPPED;
    end else begin
      decode_region = REGION_RAM;
    end
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with drop-on-full, sticky overflow flag and a registered
// high-water flag that asserts FULL_MARGIN slots before the FIFO is full.
module byte_fifo #(
  parameter int DEPTH       = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       full_o,
  output logic       almost_full_o,
  output logic       overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] HWM_C   = CW'(DEPTH - FULL_MARGIN);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          af_q, af_d;
  logic          ovf_q, ovf_d;
  logic          do_pop, do_push;

  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    do_push  = push_i && ((count_q != DEPTH_C) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
    af_d  = (count_d >= HWM_C);
    ovf_d = ovf_q | (push_i & ~do_push);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign valid_o       = (count_q != '0);
  assign data_o        = valid_o ? mem_q[rd_ptr_q] : 8'h00;
  assign full_o        = (count_q == DEPTH_C);
  assign almost_full_o = af_q;
  assign overflow_o    = ovf_q;

endmodule

// File: rtl/mem_io_responder.sv
// Device side of the core's byte-wide RAM bus: 128 KB RAM, UART TX FIFO,
// UART RX read port, free-running cycle counter with snapshot, program stop.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int    RAM_ADDR_W  = RAM_ADDR_W_DEF,
  parameter int    TX_DEPTH    = 16,
  parameter int    FULL_MARGIN = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_byte,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        rx_pop,
  output logic        prog_stop,
  output logic        tx_overflow
);

  localparam int RAM_DEPTH = 1 << RAM_ADDR_W;

  logic [17:0]           addr18;
  logic [RAM_ADDR_W-1:0] ram_addr;
  logic                  unused_addr_hi;
  logic                  unused_tx_full;
  region_e               region;

  logic [7:0]  ram_q [RAM_DEPTH];
  logic [7:0]  ram_rd_q;
  logic        ram_we;
  rsel_e       rsel_q, rsel_d;
  logic [7:0]  io_rd_q, io_rd_d;
  logic [31:0] cyc_q;
  logic [31:0] snap_q, snap_d;
  logic        stop_q, stop_d;
  logic        tx_push;
  logic [7:0]  tx_push_byte;

  assign addr18         = cpu_addr[17:0];
  assign ram_addr       = cpu_addr[RAM_ADDR_W-1:0];
  assign unused_addr_hi = ^cpu_addr[31:18];

  always_comb begin
    region       = decode_region(addr18);
    rsel_d       = RSEL_IO;
    io_rd_d      = 8'h00;
    snap_d       = snap_q;
    stop_d       = stop_q;
    rx_pop       = 1'b0;
    ram_we       = 1'b0;
    tx_push      = 1'b0;
    tx_push_byte = 8'h00;
    if (!cpu_wr) begin
      if (region == REGION_RAM) begin
        rsel_d = RSEL_RAM;
      end else if (region == REGION_IO) begin
        // Byte 0 of the counter freezes all four bytes so a word load is coherent.
        case (addr18)
          IO_BASE: begin
            if (rx_valid) begin
              io_rd_d = rx_byte;
              rx_pop  = 1'b1;
            end
          end
          IO_CLK: begin
            io_rd_d = cyc_q[7:0];
            snap_d  = cyc_q;
          end
          IO_CLK + 18'd1: io_rd_d = snap_q[15:8];
          IO_CLK + 18'd2: io_rd_d = snap_q[23:16];
          IO_CLK + 18'd3: io_rd_d = snap_q[31:24];
          default: ;
        endcase
      end
    end else begin
      if (region == REGION_RAM) begin
        ram_we = 1'b1;
      end else if (region == REGION_IO) begin
        if (addr18 == IO_BASE && cpu_wdata != 8'h00) begin
          tx_push      = 1'b1;
          tx_push_byte = cpu_wdata;
        end else if (addr18 == IO_CLK) begin
          stop_d       = 1'b1;
          tx_push      = 1'b1;
          tx_push_byte = 8'h00;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rsel_q  <= RSEL_IO;
      io_rd_q <= 8'h00;
      cyc_q   <= 32'h0;
      snap_q  <= 32'h0;
      stop_q  <= 1'b0;
    end else begin
      rsel_q  <= rsel_d;
      io_rd_q <= io_rd_d;
      cyc_q   <= cyc_q + 32'd1;
      snap_q  <= snap_d;
      stop_q  <= stop_d;
    end
  end

  // RAM array carries no reset; a reset forces rsel_q to the cleared I/O byte instead.
  always_ff @(posedge clk_in) begin
    if (ram_we) begin
      ram_q[ram_addr] <= cpu_wdata;
    end
    if (!cpu_wr) begin
      ram_rd_q <= ram_q[ram_addr];
    end
  end

  assign cpu_rdata = (rsel_q == RSEL_RAM) ? ram_rd_q : io_rd_q;
  assign prog_stop = stop_q;

  // tx_valid/tx_ready: a byte moves on every edge where both are high; while
  // tx_valid is high and tx_ready is low, tx_byte holds the same head byte.
  byte_fifo #(
    .DEPTH       (TX_DEPTH),
    .FULL_MARGIN (FULL_MARGIN)
  ) u_tx_fifo (
    .clk_i         (clk_in),
    .rst_i         (rst_in),
    .push_i        (tx_push),
    .data_i        (tx_push_byte),
    .pop_i         (tx_ready),
    .data_o        (tx_byte),
    .valid_o       (tx_valid),
    .full_o        (unused_tx_full),
    .almost_full_o (io_buffer_full),
    .overflow_o    (tx_overflow)
  );

endmodule
